// File: rtl/regfile_seq_master_if.sv
// Port bundle for regfile_seq_master: command channel, dump stream, register-file drive and debug state.
// master = the sequencer; slave = controller, stream consumer and register file.
interface regfile_seq_master_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  // cmd_* and out_*: a word moves on a rising edge where valid && ready are both high;
  // the out_* source holds addr/data stable while valid && !ready.
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_op;
  logic [ADDR_W-1:0] cmd_rd;
  logic [ADDR_W-1:0] cmd_rs1;
  logic [ADDR_W-1:0] cmd_rs2;
  logic              busy;
  logic              done;
  logic              out_valid;
  logic              out_ready;
  logic [ADDR_W-1:0] out_addr;
  logic [DATA_W-1:0] out_data;
  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic [ADDR_W-1:0] rf_raddr1;
  logic [ADDR_W-1:0] rf_raddr2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic [1:0]        dbg_state;

  modport master (
    input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, out_ready, rf_rdata1, rf_rdata2,
    output cmd_ready, busy, done, out_valid, out_addr, out_data,
           rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2, dbg_state
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, out_ready, rf_rdata1, rf_rdata2,
    input  cmd_ready, busy, done, out_valid, out_addr, out_data,
           rf_we, rf_waddr, rf_wdata, rf_raddr1, rf_raddr2, dbg_state
  );
endinterface

// File: rtl/regfile_seq_master.sv
// Command sequencer that is the sole driver of a 32x32 register file: CLEAR, COPY, ADD and
// a backpressured DUMP stream of every register.
module regfile_seq_master #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  regfile_seq_master_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_CLEAR = 2'd1,
    S_EXEC  = 2'd2,
    S_DUMP  = 2'd3
  } state_t;

  localparam logic [1:0]        OP_CLEAR = 2'b00;
  localparam logic [1:0]        OP_ADD   = 2'b10;
  localparam logic [1:0]        OP_DUMP  = 2'b11;
  localparam logic [ADDR_W-1:0] CNT_LAST = '1;

  state_t            state, state_d;
  logic [ADDR_W-1:0] cnt, cnt_d;
  logic [1:0]        op_q;
  logic [ADDR_W-1:0] rd_q, rs1_q, rs2_q;
  logic              done_q, done_d;
  logic              cmd_ready, accept;

  logic              rf_we;
  logic [ADDR_W-1:0] rf_waddr, rf_raddr1, rf_raddr2, out_addr;
  logic [DATA_W-1:0] rf_wdata, out_data;
  logic              out_valid;

  // Gated by rst so the command channel reads as not-ready while reset is held.
  assign cmd_ready = (state == S_IDLE) && rst;
  assign accept    = bus.cmd_valid && cmd_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      done_q <= 1'b0;
      op_q   <= '0;
      rd_q   <= '0;
      rs1_q  <= '0;
      rs2_q  <= '0;
    end else begin
      state  <= state_d;
      cnt    <= cnt_d;
      done_q <= done_d;
      if (accept) begin
        op_q  <= bus.cmd_op;
        rd_q  <= bus.cmd_rd;
        rs1_q <= bus.cmd_rs1;
        rs2_q <= bus.cmd_rs2;
      end
    end
  end

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    done_d    = 1'b0;
    rf_we     = 1'b0;
    rf_waddr  = '0;
    rf_wdata  = '0;
    rf_raddr1 = '0;
    rf_raddr2 = '0;
    out_valid = 1'b0;
    out_addr  = '0;
    out_data  = '0;
    case (state)
      S_IDLE: begin
        if (accept) begin
          cnt_d = '0;
          if (bus.cmd_op == OP_CLEAR)     state_d = S_CLEAR;
          else if (bus.cmd_op == OP_DUMP) state_d = S_DUMP;
          else                            state_d = S_EXEC;
        end
      end
      S_CLEAR: begin
        rf_we    = 1'b1;
        rf_waddr = cnt;
        cnt_d    = cnt + 1'b1;
        if (cnt == CNT_LAST) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_EXEC: begin
        // Reads are combinational, so rd == rs1/rs2 sees the old value and overwrites it at the edge.
        rf_raddr1 = rs1_q;
        rf_raddr2 = rs2_q;
        rf_we     = 1'b1;
        rf_waddr  = rd_q;
        rf_wdata  = (op_q == OP_ADD) ? (bus.rf_rdata1 + bus.rf_rdata2) : bus.rf_rdata1;
        state_d   = S_IDLE;
        done_d    = 1'b1;
      end
      S_DUMP: begin
        rf_raddr1 = cnt;
        out_valid = 1'b1;
        out_addr  = cnt;
        out_data  = bus.rf_rdata1;
        if (bus.out_ready) begin
          cnt_d = cnt + 1'b1;
          if (cnt == CNT_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.busy      = (state != S_IDLE);
  assign bus.done      = done_q;
  assign bus.out_valid = out_valid;
  assign bus.out_addr  = out_addr;
  assign bus.out_data  = out_data;
  assign bus.rf_we     = rf_we;
  assign bus.rf_waddr  = rf_waddr;
  assign bus.rf_wdata  = rf_wdata;
  assign bus.rf_raddr1 = rf_raddr1;
  assign bus.rf_raddr2 = rf_raddr2;
  assign bus.dbg_state = state;

endmodule

// File: tb/tb_regfile_seq_master.sv
// Bench for regfile_seq_master: register-file model, command-level reference model,
// directed table, hand-written corner sequences and randomized commands.
module tb_regfile_seq_master;

  localparam logic [1:0] OP_CLEAR = 2'b00;
  localparam logic [1:0] OP_COPY  = 2'b01;
  localparam logic [1:0] OP_ADD   = 2'b10;
  localparam logic [1:0] OP_DUMP  = 2'b11;

  logic clk;
  logic rst;

  regfile_seq_master_if #(.DATA_W(32), .ADDR_W(5)) bus ();

  regfile_seq_master #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- register file model ----------------
  logic [31:0] mem [32];
  logic        pl_en;
  logic [4:0]  pl_addr;
  logic [31:0] pl_data;

  always @(posedge clk) begin
    if (pl_en)          mem[pl_addr] <= pl_data;
    else if (bus.rf_we) mem[bus.rf_waddr] <= bus.rf_wdata;
  end
  assign bus.rf_rdata1 = mem[bus.rf_raddr1];
  assign bus.rf_rdata2 = mem[bus.rf_raddr2];

  // ---------------- reference model / scoreboard ----------------
  logic [31:0] ref_mem [32];
  logic [31:0] exp_q[$];
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=0x%08h required=0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [4:0] a, input logic [31:0] d);
    pl_en = 1'b1; pl_addr = a; pl_data = d;
    tick();
    pl_en = 1'b0;
    ref_mem[a] = d;
  endtask

  task automatic model_apply(input logic [1:0] op, input logic [4:0] rd,
                             input logic [4:0] rs1, input logic [4:0] rs2);
    logic [31:0] s;
    case (op)
      OP_CLEAR: for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
      OP_COPY:  ref_mem[rd] = ref_mem[rs1];
      OP_ADD: begin
        s = ref_mem[rs1] + ref_mem[rs2];
        ref_mem[rd] = s;
      end
      default: for (int i = 0; i < 32; i++) exp_q.push_back(ref_mem[i]);
    endcase
  endtask

  task automatic compare_all(input string name);
    for (int i = 0; i < 32; i++) check(name, mem[i], ref_mem[i]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic accept_cmd(input logic [1:0] op, input logic [4:0] rd,
                            input logic [4:0] rs1, input logic [4:0] rs2);
    int g = 0;
    while (!bus.cmd_ready && g < 100) begin tick(); g++; end
    check("cmd_ready_idle", {31'b0, bus.cmd_ready}, 32'd1);
    bus.cmd_valid = 1'b1;
    bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
    tick();
    bus.cmd_valid = 1'b0;
    check("busy_after_accept", {31'b0, bus.busy}, 32'd1);
    check("done_one_cycle", {31'b0, bus.done}, 32'd0);
  endtask

  // Returns in the done cycle; cyc counts cycles after the accept edge up to and including done.
  task automatic run_cmd(input logic [1:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input int rdy_mode, input bit intrude,
                         output int cyc, output int nwr);
    logic [4:0]  exp_wa, exp_a, h_addr;
    logic [31:0] h_data, exp_d;
    bit held, finished;
    int nhs;
    accept_cmd(op, rd, rs1, rs2);
    model_apply(op, rd, rs1, rs2);
    cyc = 0; nwr = 0; nhs = 0; exp_wa = 0; exp_a = 0;
    held = 0; finished = 0; h_addr = 0; h_data = 0;
    for (int k = 0; k < 400 && !finished; k++) begin
      cyc++;
      if (bus.done) begin
        finished = 1;
      end else begin
        if (intrude && cyc == 5) begin
          bus.cmd_valid = 1'b1;
          bus.cmd_op = OP_COPY; bus.cmd_rd = 5'd7; bus.cmd_rs1 = 5'd3; bus.cmd_rs2 = 5'd0;
          check("busy_reject_ready", {31'b0, bus.cmd_ready}, 32'd0);
        end
        if (intrude && cyc == 6) bus.cmd_valid = 1'b0;
        if (op == OP_DUMP) begin
          case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ((cyc % 2) == 1);
            default: bus.out_ready = 1'($urandom_range(0, 1));
          endcase
        end
        if (bus.rf_we) begin
          nwr++;
          if (op == OP_CLEAR) begin
            check("clear_waddr", {27'b0, bus.rf_waddr}, {27'b0, exp_wa});
            check("clear_wdata", bus.rf_wdata, 32'h0);
            exp_wa++;
          end
        end
        if (op == OP_DUMP) begin
          check("dump_valid", {31'b0, bus.out_valid}, 32'd1);
          if (held) begin
            check("dump_hold_addr", {27'b0, bus.out_addr}, {27'b0, h_addr});
            check("dump_hold_data", bus.out_data, h_data);
          end
          if (bus.out_ready) begin
            nhs++;
            exp_d = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
            check("dump_addr", {27'b0, bus.out_addr}, {27'b0, exp_a});
            check("dump_data", bus.out_data, exp_d);
            exp_a++;
            held = 0;
          end else begin
            held = 1; h_addr = bus.out_addr; h_data = bus.out_data;
          end
        end
        tick();
      end
    end
    bus.out_ready = 1'b0;
    if (!finished) begin
      check("done_timeout", 32'd0, 32'd1);
    end else begin
      check("done_ready", {31'b0, bus.cmd_ready}, 32'd1);
      check("done_busy", {31'b0, bus.busy}, 32'd0);
      check("done_out_valid", {31'b0, bus.out_valid}, 32'd0);
      if (op == OP_DUMP) begin
        check("dump_words", nhs, 32'd32);
        check("dump_queue_left", exp_q.size(), 32'd0);
      end
    end
    exp_q.delete();
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [1:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] exp_val;
    int          exp_cyc;
  } vec_t;
  vec_t vecs[5];

  initial begin
    int cyc, nwr, g;
    logic [1:0] op;
    logic [4:0] rd, rs1, rs2;
    int r;

    vecs[0] = '{OP_COPY, 5'd7,  5'd3, 5'd0, 32'h0000_0005, 2};
    vecs[1] = '{OP_ADD,  5'd8,  5'd3, 5'd4, 32'h0000_0003, 2};
    vecs[2] = '{OP_ADD,  5'd3,  5'd3, 5'd3, 32'h0000_000A, 2};
    vecs[3] = '{OP_ADD,  5'd9,  5'd4, 5'd4, 32'hFFFF_FFFC, 2};
    vecs[4] = '{OP_COPY, 5'd10, 5'd8, 5'd0, 32'h0000_0003, 2};

    for (int i = 0; i < 32; i++) ref_mem[i] = 32'h0;
    rst = 1'b1; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
    bus.out_ready = 1'b0;

    // Reset held: every output low.
    #3 rst = 1'b0;
    #20;
    check("rst_cmd_ready", {31'b0, bus.cmd_ready}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_done", {31'b0, bus.done}, 32'd0);
    check("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    check("rst_out_bus", {27'b0, bus.out_addr} | bus.out_data, 32'd0);
    check("rst_rf_we", {31'b0, bus.rf_we}, 32'd0);
    check("rst_rf_addrs", {17'b0, bus.rf_waddr, bus.rf_raddr1, bus.rf_raddr2}, 32'd0);
    check("rst_rf_wdata", bus.rf_wdata, 32'd0);
    check("rst_state", {30'b0, bus.dbg_state}, 32'd0);
    @(posedge clk); #1 rst = 1'b1;
    #1;
    check("post_rst_ready", {31'b0, bus.cmd_ready}, 32'd1);
    check("post_rst_busy", {31'b0, bus.busy}, 32'd0);
    check("post_rst_done", {31'b0, bus.done}, 32'd0);

    // CLEAR over nonzero contents, with a COPY presented mid-way.
    for (int i = 0; i < 32; i++) preload(5'(i), 32'hA5A5_0000 + 32'(i) + 32'h1);
    run_cmd(OP_CLEAR, 5'd0, 5'd0, 5'd0, 0, 1'b1, cyc, nwr);
    check("clear_cycles", cyc, 32'd33);
    check("clear_writes", nwr, 32'd32);
    compare_all("clear_mem");
    for (int i = 0; i < 3; i++) begin
      tick();
      check("no_late_write", {31'b0, bus.rf_we}, 32'd0);
    end

    // COPY / ADD table.
    preload(5'd3, 32'h0000_0005);
    preload(5'd4, 32'hFFFF_FFFE);
    for (int i = 0; i < 5; i++) begin
      run_cmd(vecs[i].op, vecs[i].rd, vecs[i].rs1, vecs[i].rs2, 0, 1'b0, cyc, nwr);
      check("vec_cycles", cyc, 32'(vecs[i].exp_cyc));
      check("vec_writes", nwr, 32'd1);
      check("vec_result", mem[vecs[i].rd], vecs[i].exp_val);
    end

    // DUMP with out_ready toggling every other cycle.
    for (int i = 0; i < 32; i++) preload(5'(i), 32'(i) * 32'h11);
    run_cmd(OP_DUMP, 5'd0, 5'd0, 5'd0, 1, 1'b0, cyc, nwr);
    check("dump_cycles", cyc, 32'd64);
    check("dump_no_write", nwr, 32'd0);

    // COPY ignored while busy in DUMP, then accepted in the done cycle.
    preload(5'd3, 32'h0000_0033);
    run_cmd(OP_DUMP, 5'd0, 5'd0, 5'd0, 0, 1'b1, cyc, nwr);
    check("dump_full_rate_cycles", cyc, 32'd33);
    check("reject_r7_kept", mem[7], 32'h0000_0077);
    run_cmd(OP_COPY, 5'd7, 5'd3, 5'd0, 0, 1'b0, cyc, nwr);
    check("done_cycle_copy_cycles", cyc, 32'd2);
    check("done_cycle_copy_r7", mem[7], 32'h0000_0033);

    // Randomized commands against the reference model.
    for (int i = 0; i < 32; i++) preload(5'(i), $urandom);
    for (int n = 0; n < 50; n++) begin
      r = $urandom_range(0, 11);
      rd = 5'($urandom_range(0, 31)); rs1 = 5'($urandom_range(0, 31)); rs2 = 5'($urandom_range(0, 31));
      if (r == 0)     op = OP_CLEAR;
      else if (r < 3) op = OP_DUMP;
      else if (r < 7) op = OP_COPY;
      else            op = OP_ADD;
      run_cmd(op, rd, rs1, rs2, 2, 1'b0, cyc, nwr);
      if (op == OP_COPY || op == OP_ADD) check("rand_result", mem[rd], ref_mem[rd]);
      if (op == OP_CLEAR) begin
        check("rand_clear_cycles", cyc, 32'd33);
        for (int j = 0; j < 4; j++) preload(5'($urandom_range(0, 31)), $urandom);
      end
    end
    compare_all("rand_final_mem");

    // Reset in the middle of CLEAR at cnt == 10.
    for (int i = 0; i < 32; i++) preload(5'(i), 32'(i) * 32'h11 + 32'h1);
    accept_cmd(OP_CLEAR, 5'd0, 5'd0, 5'd0);
    g = 0;
    while (!(bus.rf_we && bus.rf_waddr == 5'd10) && g < 50) begin tick(); g++; end
    check("midrst_reached_cnt10", {27'b0, bus.rf_waddr}, 32'd10);
    rst = 1'b0;
    #1;
    check("midrst_we_drop", {31'b0, bus.rf_we}, 32'd0);
    check("midrst_busy", {31'b0, bus.busy}, 32'd0);
    check("midrst_state", {30'b0, bus.dbg_state}, 32'd0);
    for (int i = 0; i < 2; i++) begin
      tick();
      check("midrst_no_done", {31'b0, bus.done}, 32'd0);
      check("midrst_no_write", {31'b0, bus.rf_we}, 32'd0);
    end
    rst = 1'b1;
    #1;
    check("midrst_ready_after", {31'b0, bus.cmd_ready}, 32'd1);
    check("midrst_done_after", {31'b0, bus.done}, 32'd0);
    for (int i = 0; i < 10; i++) ref_mem[i] = 32'h0;
    compare_all("midrst_mem");
    run_cmd(OP_COPY, 5'd20, 5'd15, 5'd0, 0, 1'b0, cyc, nwr);
    check("midrst_resume_copy", mem[20], 32'(15) * 32'h11 + 32'h1);

    tick();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
